// File: rtl/elastic_reg_pkg.sv
// elastic_reg_pkg: shared FSM state type and stall counter width for elastic_reg_rtl
package elastic_reg_pkg;
  typedef enum logic [1:0] {EMPTY, HALF, FULL} elastic_state_t;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/en_reg_rtl.sv
// en_reg_rtl: enable register, ports clk rst en d q; loads RESET_VAL on rst, holds q unless en
module en_reg_rtl #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/elastic_reg_rtl.sv
// elastic_reg_rtl: val/rdy elastic register with 2-entry skid (clk rst flush, in_val/in_rdy/in_msg, out_val/out_rdy/out_msg, occupancy; stall_cnt when ELASTIC_REG_STALL_CNT_EN)
module elastic_reg_rtl import elastic_reg_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [WIDTH-1:0]       in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_msg,
  output logic [1:0]             occupancy
`ifdef ELASTIC_REG_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
  elastic_state_t state_q, state_d;
  logic enq, deq, main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;
  always_comb begin
    in_rdy = (state_q != FULL) && !rst;
    out_val = state_q != EMPTY;
    occupancy = state_q == FULL ? 2'd2 : state_q == HALF ? 2'd1 : 2'd0;
    enq = in_val && in_rdy;
    deq = out_val && out_rdy;
    main_en = !flush && ((state_q == EMPTY && enq) || (state_q == HALF && enq && deq) || (state_q == FULL && deq));
    skid_en = !flush && state_q == HALF && enq && !deq;
    main_d = state_q == FULL ? skid_q : in_msg;
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (enq ? HALF : EMPTY) :
              state_q == HALF ? (enq && !deq ? FULL : !enq && deq ? EMPTY : HALF) :
              (deq ? HALF : FULL);
  end
  always_ff @(posedge clk)
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  en_reg_rtl #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(out_msg)
  );
  en_reg_rtl #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk(clk), .rst(rst), .en(skid_en), .d(in_msg), .q(skid_q)
  );
`ifdef ELASTIC_REG_STALL_CNT_EN
  always_ff @(posedge clk)
    if (rst || flush) stall_cnt <= '0;
    else if (out_val && !out_rdy && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_elastic_reg_rtl.sv
// tb_elastic_reg_rtl: directed self-checking bench for elastic_reg_rtl
module tb_elastic_reg_rtl;
  logic clk = 0, rst, flush, in_val, in_rdy, out_val, out_rdy;
  logic [7:0] in_msg, out_msg;
  logic [1:0] occupancy;
  int n_chk = 0, n_fail = 0;
`ifdef ELASTIC_REG_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  elastic_reg_rtl #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .occupancy(occupancy)
`ifdef ELASTIC_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; flush = 0; in_val = 1; in_msg = 8'h55; out_rdy = 0;
    tick(); tick();
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_out_msg", 32'(out_msg), 32'h00);
    rst = 0; in_val = 0; #1;
    chk("post_rst_in_rdy", 32'(in_rdy), 1);
    out_rdy = 1;
    for (int i = 1; i <= 16; i++) begin
      in_val = 1; in_msg = 8'(i); tick();
      chk("stream_val", 32'(out_val), 1);
      chk("stream_msg", 32'(out_msg), 32'(i));
      chk("stream_occ", 32'(occupancy), 1);
    end
    in_val = 0; tick();
    chk("stream_drain", 32'(out_val), 0);
    out_rdy = 0; in_val = 1; in_msg = 8'hA1; tick();
    in_msg = 8'hA2; tick();
    chk("bp_occ", 32'(occupancy), 2);
    chk("bp_in_rdy", 32'(in_rdy), 0);
    chk("bp_head", 32'(out_msg), 32'hA1);
    in_msg = 8'hA3; tick();
    chk("bp_hold_head", 32'(out_msg), 32'hA1);
    out_rdy = 1; tick();
    chk("bp_msg2", 32'(out_msg), 32'hA2);
    chk("bp_occ1", 32'(occupancy), 1);
    tick();
    chk("bp_msg3", 32'(out_msg), 32'hA3);
    in_val = 0; tick();
    chk("bp_empty", 32'(out_val), 0);
    out_rdy = 0; in_val = 1; in_msg = 8'hB1; tick();
    in_msg = 8'hB2; tick();
    chk("fl_full", 32'(occupancy), 2);
    flush = 1; in_msg = 8'hB3; tick();
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_val", 32'(out_val), 0);
    flush = 0; in_val = 0; out_rdy = 1; tick();
    chk("fl_no_b3", 32'(out_val), 0);
    chk("fl_keep_main", 32'(out_msg), 32'hB1);
    out_rdy = 0; in_val = 1; in_msg = 8'hD1; tick();
    flush = 1; in_msg = 8'hD2; tick();
    chk("fl_half_occ", 32'(occupancy), 0);
    chk("fl_half_msg", 32'(out_msg), 32'hD1);
    flush = 0; in_msg = 8'hC1; tick();
    chk("sim_c1", 32'(out_msg), 32'hC1);
    in_msg = 8'hC2; out_rdy = 1; tick();
    chk("sim_c2", 32'(out_msg), 32'hC2);
    chk("sim_occ", 32'(occupancy), 1);
    out_rdy = 0; in_msg = 8'hE1; tick();
    chk("mid_full", 32'(occupancy), 2);
    rst = 1; in_val = 1; in_msg = 8'hE2; tick();
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_msg", 32'(out_msg), 32'h00);
    chk("mid_rst_rdy", 32'(in_rdy), 0);
    rst = 0; in_val = 0; out_rdy = 1; tick();
    chk("mid_rst_after", 32'(out_val), 0);
`ifdef ELASTIC_REG_STALL_CNT_EN
    chk("sc_reset", 32'(stall_cnt), 0);
    out_rdy = 0; in_val = 1; in_msg = 8'hF1; tick();
    in_val = 0;
    repeat (5) tick();
    chk("sc_five", 32'(stall_cnt), 5);
    flush = 1; tick();
    chk("sc_flush", 32'(stall_cnt), 0);
    flush = 0; in_val = 1; in_msg = 8'hF2; tick();
    in_val = 0;
    repeat (70000) tick();
    chk("sc_sat", 32'(stall_cnt), 32'hFFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
